// File: rtl/kbd_div_pkg.sv
// Shared types and helpers for the keypad-driven sequential divider.
package kbd_div_pkg;

   // FSM states; the encoding is exported directly as entry_phase.
   typedef enum logic [1:0] {
      ENTER_A = 2'b00,
      ENTER_B = 2'b01,
      DIVIDE  = 2'b10,
      DONE    = 2'b11
   } state_t;

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/kbd_divider_seq_core.sv
// Restoring divider datapath: one quotient bit per clock, W iterations.
// done is a combinational pulse during the final iteration; quotient and
// remainder are valid only while done is high and are meant to be captured.
module div_restoring_core
   import kbd_div_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int CW = cnt_w(W);

   logic          r_run;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_dvd;
   logic [W-1:0]  r_div;

   logic [W:0]    w_shift;
   logic [W:0]    w_trial;
   logic          w_qbit;
   logic          w_last;
   logic [W-1:0]  w_rem_nxt;

   // One restoring step: W+1 bit trial so a borrow shows up in the top bit.
   always_comb begin
      w_shift   = {r_rem, r_dvd[W-1]};
      w_trial   = w_shift - {1'b0, r_div};
      w_qbit    = ~w_trial[W];
      w_rem_nxt = w_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
      w_last    = r_run && (r_cnt == CW'(W-1));
   end

   // Iteration control: running flag and step counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (abort) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
      end else if (r_run) begin
         r_cnt <= r_cnt + CW'(1);
         if (w_last) r_run <= 1'b0;
      end
   end

   // Working registers; the dividend shifter collects quotient bits at its LSB.
   always_ff @(posedge clk) begin
      if (start) begin
         r_rem <= '0;
         r_dvd <= dividend;
         r_div <= divisor;
      end else if (r_run) begin
         r_rem <= w_rem_nxt;
         r_dvd <= {r_dvd[W-2:0], w_qbit};
      end
   end

   assign busy      = r_run;
   assign done      = w_last;
   assign quotient  = {r_dvd[W-2:0], w_qbit};
   assign remainder = w_rem_nxt;

endmodule

// File: rtl/kbd_divider_seq.sv
// Keypad-fed sequential divider: nibble entry of A and B, iterative divide,
// held result with a level done flag for the BCD converter downstream.
module kbd_divider_seq
   import kbd_div_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [3:0]   key_hex,
   input  logic         clear,
   output logic [W-1:0] a_val,
   output logic [W-1:0] b_val,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero,
   output logic [1:0]   entry_phase
);

   localparam int NIB = W / 4;
   localparam int NCW = cnt_w(NIB);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [NCW-1:0] r_nib;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_q;
   logic [W-1:0]   r_r;
   logic           r_dbz;

   logic           w_last_nib;
   logic [W-1:0]   w_a_next;
   logic [W-1:0]   w_b_next;
   logic           w_b_zero;
   logic           w_b_complete;
   logic           w_start;
   logic           w_core_busy;
   logic           w_core_done;
   logic [W-1:0]   w_core_q;
   logic [W-1:0]   w_core_r;

   assign w_last_nib   = (r_nib == NCW'(NIB - 1));
   assign w_a_next     = (r_a << 4) | W'(key_hex);
   assign w_b_next     = (r_b << 4) | W'(key_hex);
   assign w_b_zero     = (w_b_next == '0);
   assign w_b_complete = (r_state == ENTER_B) && key_valid && w_last_nib && !clear;
   assign w_start      = w_b_complete && !w_b_zero;

   div_restoring_core #(.W(W)) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (w_start),
      .abort     (clear),
      .dividend  (r_a),
      .divisor   (w_b_next),
      .busy      (w_core_busy),
      .done      (w_core_done),
      .quotient  (w_core_q),
      .remainder (w_core_r)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ENTER_A;
      else      r_state <= w_state_nxt;
   end

   // FSM next-state logic; clear overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ENTER_A;
      end else begin
         case (r_state)
            ENTER_A: if (key_valid && w_last_nib) w_state_nxt = ENTER_B;
            ENTER_B: if (key_valid && w_last_nib) w_state_nxt = w_b_zero ? DONE : DIVIDE;
            DIVIDE:  if (w_core_done) w_state_nxt = DONE;
            DONE:    if (key_valid) w_state_nxt = (NIB == 1) ? ENTER_B : ENTER_A;
            default: w_state_nxt = ENTER_A;
         endcase
      end
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      entry_phase = r_state;
      done        = (r_state == DONE);
      busy        = (r_state == DIVIDE) && w_core_busy;
   end

   // Operand entry, nibble counting and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nib <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dbz <= 1'b0;
      end else if (clear) begin
         r_nib <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dbz <= 1'b0;
      end else begin
         case (r_state)
            ENTER_A: begin
               if (key_valid) begin
                  r_a   <= w_a_next;
                  r_nib <= w_last_nib ? '0 : r_nib + NCW'(1);
               end
            end
            ENTER_B: begin
               if (key_valid) begin
                  r_b   <= w_b_next;
                  r_nib <= w_last_nib ? '0 : r_nib + NCW'(1);
                  if (w_last_nib && w_b_zero) begin
                     r_q   <= '1;
                     r_r   <= r_a;
                     r_dbz <= 1'b1;
                  end
               end
            end
            DIVIDE: begin
               if (w_core_done) begin
                  r_q <= w_core_q;
                  r_r <= w_core_r;
               end
            end
            DONE: begin
               if (key_valid) begin
                  r_a   <= W'(key_hex);
                  r_b   <= '0;
                  r_dbz <= 1'b0;
                  r_nib <= (NIB == 1) ? '0 : NCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign a_val       = r_a;
   assign b_val       = r_b;
   assign quotient    = r_q;
   assign remainder   = r_r;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_kbd_divider_seq.sv
// Scoreboard bench for kbd_divider_seq: W=8 and W=16 instances.
module tb_kbd_divider_seq;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          edg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   exp_t        sb8[$];
   exp_t        sb16[$];

   logic        kv8, clr8;
   logic [3:0]  kh8;
   logic [7:0]  a8, b8, q8, r8;
   logic        busy8, done8, dbz8, pd8 = 1'b0;
   logic [1:0]  ph8;

   logic        kv16, clr16;
   logic [3:0]  kh16;
   logic [15:0] a16, b16, q16, r16;
   logic        busy16, done16, dbz16, pd16 = 1'b0;
   logic [1:0]  ph16;

   kbd_divider_seq #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .key_valid(kv8), .key_hex(kh8), .clear(clr8),
      .a_val(a8), .b_val(b8), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .entry_phase(ph8)
   );

   kbd_divider_seq #(.W(16)) dut16 (
      .clk(clk), .rst(rst), .key_valid(kv16), .key_hex(kh16), .clear(clr16),
      .a_val(a16), .b_val(b16), .busy(busy16), .done(done16),
      .quotient(q16), .remainder(r16), .div_by_zero(dbz16), .entry_phase(ph16)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic press(input int which, input logic [3:0] k);
      if (which == 8) begin kv8 = 1'b1; kh8 = k; end
      else            begin kv16 = 1'b1; kh16 = k; end
      @(posedge clk); #1;
      kv8  = 1'b0;
      kv16 = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Enter n nibbles MSB-first and queue the expected result.
   task automatic enter(input int which, input logic [31:0] keys, input int n,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      exp_t e;
      for (int i = 0; i < n; i++) press(which, keys[4*(n-1-i) +: 4]);
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.edg = cyc + (edbz ? 0 : which);
      if (which == 8) sb8.push_back(e);
      else            sb16.push_back(e);
   endtask

   // Monitor for the W=8 instance: compare on each rising done.
   always @(negedge clk) begin
      exp_t e;
      if (rst && done8 && !pd8) begin
         if (sb8.size() == 0) begin
            chk("dut8 done with empty scoreboard", 32'(sb8.size()), 32'd1);
         end else begin
            e = sb8.pop_front();
            chk("dut8 quotient", 32'(q8), e.q);
            chk("dut8 remainder", 32'(r8), e.r);
            chk("dut8 div_by_zero", 32'(dbz8), 32'(e.dbz));
            chk("dut8 done edge", cyc, e.edg);
         end
      end
      pd8 <= done8;
   end

   // Monitor for the W=16 instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst && done16 && !pd16) begin
         if (sb16.size() == 0) begin
            chk("dut16 done with empty scoreboard", 32'(sb16.size()), 32'd1);
         end else begin
            e = sb16.pop_front();
            chk("dut16 quotient", 32'(q16), e.q);
            chk("dut16 remainder", 32'(r16), e.r);
            chk("dut16 div_by_zero", 32'(dbz16), 32'(e.dbz));
            chk("dut16 done edge", cyc, e.edg);
         end
      end
      pd16 <= done16;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      kv8 = 1'b0; clr8 = 1'b0; kh8 = 4'h0;
      kv16 = 1'b0; clr16 = 1'b0; kh16 = 4'h0;
      #12;
      chk("reset8 data", {a8, b8, q8, r8}, 32'h0);
      chk("reset8 flags", {busy8, done8, dbz8, ph8}, 32'h0);
      chk("reset16 data", {a16, b16}, 32'h0);
      chk("reset16 result", {q16, r16, busy16, done16, dbz16, ph16}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 0xC8 / 0x07 = 0x1C rem 0x04, done W clocks after last key
      enter(8, 32'hC807, 4, 32'h1C, 32'h04, 1'b0);
      chk("t1 busy at k0", busy8, 1'b1);
      chk("t1 phase dividing", ph8, 2'b10);
      for (int i = 1; i < 8; i++) begin
         cycles(1);
         chk("t1 busy held", busy8, 1'b1);
      end
      chk("t1 quotient not yet loaded", q8, 8'h00);
      cycles(1);
      chk("t1 done at k0+8", done8, 1'b1);
      chk("t1 busy low", busy8, 1'b0);
      chk("t1 phase done", ph8, 2'b11);
      cycles(3);
      chk("t1 done held", done8, 1'b1);
      chk("t1 quotient held", q8, 8'h1C);

      // key in DONE starts a fresh A entry
      press(8, 4'h3);
      chk("t6 done dropped", done8, 1'b0);
      chk("t6 a_val", a8, 8'h03);
      chk("t6 b_val", b8, 8'h00);
      chk("t6 phase", ph8, 2'b00);
      press(8, 4'h4);
      chk("t6 a_val second nibble", a8, 8'h34);
      chk("t6 phase B entry", ph8, 2'b01);
      // asynchronous reset mid-entry
      #2 rst = 1'b0;
      #1;
      chk("t6 async reset data", {a8, b8, q8, r8}, 32'h0);
      chk("t6 async reset flags", {busy8, done8, dbz8, ph8}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // divide by zero: done on the last key edge
      enter(8, 32'h2A00, 4, 32'hFF, 32'h2A, 1'b1);
      chk("t2 done same edge", done8, 1'b1);
      chk("t2 div_by_zero", dbz8, 1'b1);
      chk("t2 busy never", busy8, 1'b0);
      cycles(2);

      // A < B, with a key pressed mid-divide that must be ignored
      enter(8, 32'h0509, 4, 32'h00, 32'h05, 1'b0);
      chk("t3 div_by_zero cleared", dbz8, 1'b0);
      cycles(2);
      press(8, 4'h7);
      cycles(8);
      chk("t3 a_val unchanged", a8, 8'h05);
      chk("t3 b_val unchanged", b8, 8'h09);
      chk("t3 quotient", q8, 8'h00);
      chk("t3 remainder", r8, 8'h05);

      // clear 3 cycles into DIVIDE, colliding with a key
      press(8, 4'h6); press(8, 4'h4); press(8, 4'h0); press(8, 4'h3);
      cycles(2);
      clr8 = 1'b1; kv8 = 1'b1; kh8 = 4'h9;
      @(posedge clk); #1;
      clr8 = 1'b0; kv8 = 1'b0;
      chk("t4 clear data", {a8, b8, q8, r8}, 32'h0);
      chk("t4 clear flags", {busy8, done8, dbz8, ph8}, 32'h0);
      cycles(12);
      chk("t4 no done after abort", done8, 1'b0);
      press(8, 4'h1);
      chk("t4 a_val refill", a8, 8'h01);
      chk("t4 phase A entry", ph8, 2'b00);

      // W=16: 0xFFFF / 0x0010
      enter(16, 32'hFFFF0010, 8, 32'h0FFF, 32'h000F, 1'b0);
      cycles(18);
      chk("t5 quotient", q16, 16'h0FFF);
      chk("t5 remainder", r16, 16'h000F);
      chk("t5 done held", done16, 1'b1);

      chk("sb8 drained", 32'(sb8.size()), 32'd0);
      chk("sb16 drained", 32'(sb16.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_divider_seq.md
Name: kbd_divider_seq

Overview:
- Parametrised successor to the single-cycle debug divider path.
- Takes W-bit operands A and B from hex keypad nibbles, entered MSB-first.
- Divides them with an iterative restoring algorithm that produces one quotient bit per clock.
- Sits between the keypad/debounce front end and the bin2bcd + display_7seg back end. Its done flag is a level-held start for the BCD converter.

Parameters:
- W, default 8: operand, quotient and remainder width in bits. Must be a multiple of 4, range 4..32.
- NIB, default W/4: nibbles per operand. Derived; never overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- key_valid  input  1  single-cycle pulse, one per accepted key.
- key_hex  input  4  key value; sampled only when key_valid=1.
- clear  input  1  synchronous abort; returns the block to operand-A entry.
- a_val  output  W  operand A as entered so far.
- b_val  output  W  operand B as entered so far.
- busy  output  1  high while in DIVIDE.
- done  output  1  high in DONE; held until the next key_valid or clear.
- quotient  output  W  registered result.
- remainder  output  W  registered result.
- div_by_zero  output  1  set with done when B==0.
- entry_phase  output  2  00=A entry, 01=B entry, 10=dividing, 11=done (display/LED use).

Behaviour:
- Reset (rst=0, async):
  - FSM goes to ENTER_A and the nibble counter clears.
  - All outputs go to 0: a_val, b_val, quotient, remainder, busy, done, div_by_zero, entry_phase.
- States and transitions:
  - ENTER_A: on key_valid, a_val <= {a_val[W-5:0], key_hex} and the nibble count increments. The edge that takes the NIB-th nibble moves to ENTER_B with the count reset to 0.
  - ENTER_B: same shifting into b_val. The edge that takes the NIB-th nibble (edge k0) moves to DIVIDE, or to DONE if the completed B value is 0.
  - DIVIDE: busy=1. Working registers initialise at k0: partial remainder=0, dividend shift=A, iteration count=0.
  - Each DIVIDE edge performs one restoring step:
    - shift {rem,dividend} left 1;
    - trial = rem - B;
    - if trial is non-negative, rem <= trial and the quotient LSB is 1, else the LSB is 0.
  - At edge k0+W (the W-th iteration), quotient and remainder load, done=1, busy=0, and the FSM moves to DONE.
  - Latency: done rises exactly W clocks after the last-B-nibble edge.
  - DONE: results and operands hold. On key_valid, b_val clears and a_val <= {(W-4) zeros, key_hex}. done and div_by_zero clear, nibble count=1, and the FSM moves to ENTER_A (or to ENTER_B if NIB==1).
- Division by zero:
  - At k0 the FSM goes directly to DONE, so done rises at edge k0 (latency 0).
  - quotient={W{1}}, remainder=A, div_by_zero=1.
- key_valid during DIVIDE is ignored; no buffering.
- clear:
  - Acts in any state, with priority over a simultaneous key_valid.
  - Next edge: FSM goes to ENTER_A; a_val, b_val, counters, busy, done and div_by_zero clear.
  - quotient and remainder also clear.
  - A clear during DIVIDE aborts the operation with no done pulse.
- rst asserted mid-operation has the same effect as reset at power-up.
- quotient and remainder change only at entry to DONE or on clear/reset; they never show intermediate iteration values.
- Arithmetic is unsigned. The partial remainder is W+1 bits internally so the trial subtraction sign is visible. Always remainder < B when B≠0.

Decomposition:
- Package kbd_div_pkg:
  - state enum (ENTER_A, ENTER_B, DIVIDE, DONE), encoded to match entry_phase;
  - clog2-based width for the iteration and nibble counters.
- Sub-module div_restoring_core #(W):
  - ports: start, dividend, divisor, busy, done pulse, quotient, remainder;
  - holds the iterative datapath and iteration counter.
- The top level owns key entry, the FSM, zero detection and result registers.

Test Plan:
- W=8: keys C,8,0,7 -> busy for 8 cycles, done at last-key edge+8; quotient=0x1C, remainder=0x04, div_by_zero=0.
- W=8: keys 2,A,0,0 -> done on the same edge as the last key; quotient=0xFF, remainder=0x2A, div_by_zero=1.
- W=8: keys 0,5,0,9 (A<B) -> quotient=0x00, remainder=0x05. Keys pressed mid-divide are ignored and the result is unchanged.
- W=8: clear asserted 3 cycles into DIVIDE (with a simultaneous key_valid) -> no done; all outputs 0; next keys fill a_val from 0.
- W=16: keys F,F,F,F,0,0,1,0 -> done after 16 cycles; quotient=0x0FFF, remainder=0x000F.
- W=8: key 3 pressed while in DONE -> done drops; a_val=0x03, b_val=0x00, entry_phase=00. Separately, rst pulsed low mid-entry -> all outputs 0 asynchronously.
